hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard controller on the consuming end of the ID/EX register. It reads the EX-side copies of the control fields (MemRead, Rd, setflags) and compares them against the instruction decoding in ID. It also takes the EX-resolved branch outcome. From these it drives PC/IF-ID write enables, the IF/ID flush and the ID/EX bubble (zeroing of the control bits), and it keeps saturating stall/flush performance counters.

Parameters:
FLUSH_CYCLES, 1, cycles of squash after a taken branch seen in EX (legal 1..3)
CNT_W, 16, width of the stall and flush performance counters

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high
MemRead_IDEX  in  1  instruction in EX is a load
setflags_IDEX  in  1  instruction in EX writes NZCV
Rd_EX  in  5  destination register of instruction in EX
Rn_ID  in  5  first source register of instruction in ID
Rm_ID  in  5  second source register of instruction in ID
usesRn_ID  in  1  ID instruction reads Rn
usesRm_ID  in  1  ID instruction reads Rm
condBr_ID  in  1  ID instruction is B.cond (reads flags)
brTaken_EX  in  1  branch in EX resolved taken this cycle
mem_busy  in  1  data memory not ready; freezes whole pipe
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register load enable
ifid_flush  out  1  IF/ID loads a NOP
idex_bubble  out  1  ID/EX control bits loaded as zero
stall_cnt  out  CNT_W  cycles spent in load/flag stall
flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- State machine: RUN, FLUSH. A down-counter flush_left (2 bits) is used in FLUSH. Control outputs are combinational from the current state and the inputs. State and counters are registered.
- Reset (held high): state=RUN, flush_left=0, stall_cnt=0, flush_cnt=0. While reset is high: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1. Reset mid-flush aborts the flush. The first cycle after reset is RUN.
- Hazard terms:
  - load_haz = MemRead_IDEX & Rd_EX!=31 & ((usesRn_ID & Rn_ID==Rd_EX) | (usesRm_ID & Rm_ID==Rd_EX)). X31 is never a hazard.
  - flag_haz = setflags_IDEX & condBr_ID.
- Priority, evaluated each cycle, first match wins:
  1. mem_busy=1: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0. State, flush_left and counters are frozen, and brTaken_EX is ignored. brTaken_EX must stay asserted until the freeze is released.
  2. brTaken_EX=1 in RUN, or state=FLUSH: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. Hazards are ignored because the ID instruction is squashed.
     - On entry from RUN: flush_cnt+1 (saturating). If FLUSH_CYCLES>1, go to FLUSH with flush_left=FLUSH_CYCLES-1; else stay in RUN.
     - In FLUSH: flush_left decrements each cycle. On the cycle flush_left==1, return to RUN.
     - brTaken_EX asserted while in FLUSH is ignored: no restart, no count.
  3. load_haz | flag_haz: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1. stall_cnt+1 (saturating). This is a single-cycle stall by construction, since the bubble removes the hazard next cycle. Load and flag hazards together count once.
  4. Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Latency: outputs react in the same cycle. Counter and state changes are visible the cycle after the triggering edge.

Test Plan:
1. Reset held 2 cycles, then released with all inputs 0 -> outputs during reset are 0/0/1/1. After release: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, stall_cnt=0, flush_cnt=0.
2. MemRead_IDEX=1, Rd_EX=5, Rn_ID=5, usesRn_ID=1 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1, stall_cnt=1 next cycle. Repeat with Rd_EX=31 -> no stall. Repeat with usesRn_ID=0 -> no stall.
3. setflags_IDEX=1 and condBr_ID=1 -> one-cycle stall, stall_cnt increments. Then the same cycle plus a load hazard -> stall_cnt increments once only.
4. FLUSH_CYCLES=2, brTaken_EX=1 for one cycle, concurrent with a load hazard -> ifid_flush=1 and idex_bubble=1 for 2 cycles, pc_write=1 both cycles, flush_cnt=1, stall_cnt unchanged. brTaken_EX re-pulsed in the 2nd cycle -> flush_cnt stays 1.
5. mem_busy=1 for 3 cycles during FLUSH (flush_left=1) -> all enables 0 and counters frozen. After release, one remaining flush cycle, then RUN.
6. Preload stall_cnt to 0xFFFE (or CNT_W=2 build) and force 4 stalls -> counter stops at all-ones. Assert reset mid-FLUSH -> state RUN and counters 0 on the first cycle after release.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the ID/EX pipeline boundary and the hazard controller.
// The pipeline side drives the decode/EX fields; the controller drives enables and counters.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             MemRead_IDEX;
  logic             setflags_IDEX;
  logic [4:0]       Rd_EX;
  logic [4:0]       Rn_ID;
  logic [4:0]       Rm_ID;
  logic             usesRn_ID;
  logic             usesRm_ID;
  logic             condBr_ID;
  logic             brTaken_EX;
  logic             mem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output MemRead_IDEX, setflags_IDEX, Rd_EX, Rn_ID, Rm_ID,
           usesRn_ID, usesRm_ID, condBr_ID, brTaken_EX, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, stall_cnt, flush_cnt
  );

  modport slave (
    input  MemRead_IDEX, setflags_IDEX, Rd_EX, Rn_ID, Rm_ID,
           usesRn_ID, usesRm_ID, condBr_ID, brTaken_EX, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_bubble, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / flag-use stall and taken-branch squash control for the IF/ID and ID/EX registers.
//   state    | meaning
//   ST_RUN   | normal issue; stalls on load/flag hazards, enters squash on a taken branch
//   ST_FLUSH | squashing younger instructions, flush_left cycles remain including this one
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [1:0] FLUSH_LEFT_INIT = 2'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       flush_left_q, flush_left_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;
  logic             load_haz, flag_haz, squash;
  logic             pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c;

  // X31 reads as zero, so a load targeting it never creates a dependency.
  assign load_haz = hz.MemRead_IDEX && (hz.Rd_EX != 5'd31) &&
                    ((hz.usesRn_ID && (hz.Rn_ID == hz.Rd_EX)) ||
                     (hz.usesRm_ID && (hz.Rm_ID == hz.Rd_EX)));
  assign flag_haz = hz.setflags_IDEX && hz.condBr_ID;
  assign squash   = (state_q == ST_FLUSH) || (hz.brTaken_EX && (state_q == ST_RUN));

  always_comb begin
    state_d       = state_q;
    flush_left_d  = flush_left_q;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    pc_write_c    = 1'b1;
    ifid_write_c  = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    if (reset) begin
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
    end else if (hz.mem_busy) begin
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
    end else if (squash) begin
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
      if (state_q == ST_RUN) begin
        flush_inc = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d      = ST_FLUSH;
          flush_left_d = FLUSH_LEFT_INIT;
        end
      end else begin
        flush_left_d = flush_left_q - 2'd1;
        if (flush_left_q == 2'd1) begin
          state_d = ST_RUN;
        end
      end
    end else if (load_haz || flag_haz) begin
      // The bubble clears the dependency, so this never lasts past one cycle.
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      idex_bubble_c = 1'b1;
      stall_inc     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      flush_left_q <= 2'd0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
      if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign hz.pc_write    = pc_write_c;
  assign hz.ifid_write  = ifid_write_c;
  assign hz.ifid_flush  = ifid_flush_c;
  assign hz.idex_bubble = idex_bubble_c;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table on a FLUSH_CYCLES=2/CNT_W=4 build, then random
// stimulus on that build and a FLUSH_CYCLES=3/CNT_W=16 build against a behavioural model.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(4))  if_a ();
  hazard_ctrl_if #(.CNT_W(16)) if_b ();

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .hz(if_a.slave));
  hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .hz(if_b.slave));

  typedef struct {
    logic       rst, mr, sf;
    logic [4:0] rd, rn, rm;
    logic       urn, urm, cb, br, busy;
    logic [3:0] exp_o;   // {pc_write, ifid_write, ifid_flush, idex_bubble}
    int         exp_s, exp_f;
  } vec_t;

  vec_t vt[$];
  int checks = 0;
  int failures = 0;

  // Model state: remaining squash cycles and counter values, per build.
  int m_left[2];
  int m_stall[2];
  int m_flush[2];
  int fc[2]   = '{2, 3};
  int cmax[2] = '{15, 65535};

  function automatic vec_t v(input logic rst, mr, sf, input logic [4:0] rd, rn, rm,
                             input logic urn, urm, cb, br, busy,
                             input logic [3:0] eo, input int es, ef);
    vec_t x;
    x.rst = rst; x.mr = mr; x.sf = sf; x.rd = rd; x.rn = rn; x.rm = rm;
    x.urn = urn; x.urm = urm; x.cb = cb; x.br = br; x.busy = busy;
    x.exp_o = eo; x.exp_s = es; x.exp_f = ef;
    return x;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_cycle(input int k, input vec_t x, output logic [3:0] eo,
                             output int es, output int ef);
    bit lh, fh;
    es = m_stall[k];
    ef = m_flush[k];
    lh = x.mr && (x.rd != 5'd31) && ((x.urn && x.rn == x.rd) || (x.urm && x.rm == x.rd));
    fh = x.sf && x.cb;
    if (x.rst) begin
      eo = 4'b0011;
      m_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end else if (x.busy) begin
      eo = 4'b0000;
    end else if (m_left[k] > 0) begin
      eo = 4'b1111;
      m_left[k]--;
    end else if (x.br) begin
      eo = 4'b1111;
      if (m_flush[k] < cmax[k]) m_flush[k]++;
      m_left[k] = fc[k] - 1;
    end else if (lh || fh) begin
      eo = 4'b0001;
      if (m_stall[k] < cmax[k]) m_stall[k]++;
    end else begin
      eo = 4'b1100;
    end
  endtask

  task automatic drive(input vec_t x);
    reset = x.rst;
    if_a.MemRead_IDEX = x.mr;  if_b.MemRead_IDEX = x.mr;
    if_a.setflags_IDEX = x.sf; if_b.setflags_IDEX = x.sf;
    if_a.Rd_EX = x.rd;         if_b.Rd_EX = x.rd;
    if_a.Rn_ID = x.rn;         if_b.Rn_ID = x.rn;
    if_a.Rm_ID = x.rm;         if_b.Rm_ID = x.rm;
    if_a.usesRn_ID = x.urn;    if_b.usesRn_ID = x.urn;
    if_a.usesRm_ID = x.urm;    if_b.usesRm_ID = x.urm;
    if_a.condBr_ID = x.cb;     if_b.condBr_ID = x.cb;
    if_a.brTaken_EX = x.br;    if_b.brTaken_EX = x.br;
    if_a.mem_busy = x.busy;    if_b.mem_busy = x.busy;
  endtask

  // Drive one cycle, compare mid-cycle, then advance past the next rising edge.
  task automatic apply(input vec_t x, input bit use_table, input string tag);
    logic [3:0] eo, act_a, act_b;
    int es, ef;
    drive(x);
    #3;
    act_a = {if_a.pc_write, if_a.ifid_write, if_a.ifid_flush, if_a.idex_bubble};
    act_b = {if_b.pc_write, if_b.ifid_write, if_b.ifid_flush, if_b.idex_bubble};
    model_cycle(0, x, eo, es, ef);
    if (use_table) begin
      eo = x.exp_o; es = x.exp_s; ef = x.exp_f;
    end
    chk({tag, " a.ctl"}, int'(act_a), int'(eo));
    chk({tag, " a.stall_cnt"}, int'(if_a.stall_cnt), es);
    chk({tag, " a.flush_cnt"}, int'(if_a.flush_cnt), ef);
    model_cycle(1, x, eo, es, ef);
    chk({tag, " b.ctl"}, int'(act_b), int'(eo));
    chk({tag, " b.stall_cnt"}, int'(if_b.stall_cnt), es);
    chk({tag, " b.flush_cnt"}, int'(if_b.flush_cnt), ef);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] pool [4] = '{5'd1, 5'd2, 5'd3, 5'd31};
    return pool[$urandom_range(0, 3)];
  endfunction

  initial begin
    vec_t x;
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end
    //       rst mr sf rd  rn  rm  urn urm cb br bsy exp      s  f
    vt.push_back(v(1, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 4'b0011, 0, 0));
    vt.push_back(v(1, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 4'b0011, 0, 0));
    vt.push_back(v(0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 4'b1100, 0, 0));
    vt.push_back(v(0, 1, 0, 5,  5,  0,  1, 0, 0, 0, 0, 4'b0001, 0, 0));
    vt.push_back(v(0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 4'b1100, 1, 0));
    vt.push_back(v(0, 1, 0, 31, 31, 0,  1, 0, 0, 0, 0, 4'b1100, 1, 0));
    vt.push_back(v(0, 1, 0, 5,  5,  0,  0, 0, 0, 0, 0, 4'b1100, 1, 0));
    vt.push_back(v(0, 1, 0, 7,  0,  7,  0, 1, 0, 0, 0, 4'b0001, 1, 0));
    vt.push_back(v(0, 0, 1, 0,  0,  0,  0, 0, 1, 0, 0, 4'b0001, 2, 0));
    vt.push_back(v(0, 1, 1, 5,  5,  0,  1, 0, 1, 0, 0, 4'b0001, 3, 0));
    vt.push_back(v(0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 4'b1100, 4, 0));
    vt.push_back(v(0, 1, 0, 5,  5,  0,  1, 0, 0, 1, 0, 4'b1111, 4, 0));
    vt.push_back(v(0, 0, 0, 0,  0,  0,  0, 0, 0, 1, 0, 4'b1111, 4, 1));
    vt.push_back(v(0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 4'b1100, 4, 1));
    vt.push_back(v(0, 0, 0, 0,  0,  0,  0, 0, 0, 1, 0, 4'b1111, 4, 1));
    for (int i = 0; i < 3; i++)
      vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0000, 4, 2));
    vt.push_back(v(0, 0, 0, 0,  0,  0,  0, 0, 0, 1, 0, 4'b1111, 4, 2));
    vt.push_back(v(0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 4'b1100, 4, 2));
    vt.push_back(v(0, 1, 0, 5,  5,  0,  1, 0, 0, 0, 1, 4'b0000, 4, 2));
    vt.push_back(v(0, 0, 0, 0,  0,  0,  0, 0, 0, 1, 1, 4'b0000, 4, 2));
    vt.push_back(v(0, 0, 0, 0,  0,  0,  0, 0, 0, 1, 0, 4'b1111, 4, 2));
    vt.push_back(v(0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 4'b1111, 4, 3));
    for (int i = 0; i < 13; i++)
      vt.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0001, (4 + i > 15) ? 15 : 4 + i, 3));
    vt.push_back(v(0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 4'b1100, 15, 3));
    vt.push_back(v(1, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 4'b0011, 15, 3));
    vt.push_back(v(0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 4'b1100, 0, 0));

    @(posedge clk);
    #1;
    foreach (vt[i]) apply(vt[i], 1'b1, $sformatf("vec%0d", i));

    // Reset asserted in the second squash cycle must abort the flush.
    apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 0, 0), 1'b1, "rstflush_br");
    apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 0, 1), 1'b1, "rstflush_rst");
    apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 0, 0), 1'b1, "rstflush_run");

    for (int i = 0; i < 3000; i++) begin
      x.rst  = ($urandom_range(0, 63) == 0);
      x.mr   = 1'($urandom_range(0, 1));
      x.sf   = 1'($urandom_range(0, 1));
      x.rd   = pick_reg();
      x.rn   = pick_reg();
      x.rm   = pick_reg();
      x.urn  = 1'($urandom_range(0, 1));
      x.urm  = 1'($urandom_range(0, 1));
      x.cb   = ($urandom_range(0, 2) == 0);
      x.br   = ($urandom_range(0, 4) == 0);
      x.busy = ($urandom_range(0, 5) == 0);
      x.exp_o = 4'b0000; x.exp_s = 0; x.exp_f = 0;
      apply(x, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
